lsu_dccm_mem: RTL and testbench

//  Responder side of the LSU DCCM port: banked data-closely-coupled memory that services the

---
 rtl/lsu_dccm_mem.sv | 102 ++++++++++
 tb/tb_lsu_dccm_mem.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lsu_dccm_mem.sv
// Banked DCCM responder: flop array, 1-cycle registered reads, and a one-entry write-pending
// buffer that parks writes colliding with same-cycle reads on their bank.
module lsu_dccm_mem #(
  parameter int DCCM_BITS        = 12,
  parameter int DCCM_BANK_BITS   = 2,
  parameter int DCCM_WIDTH_BITS  = 2,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        dccm_wren,
  input  logic [DCCM_BITS-1:0]        dccm_wr_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic                        dccm_rden,
  input  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                        dccm_wr_pend,
  output logic                        dccm_wr_overflow,
  output logic                        dccm_rd_conflict
);
  localparam int ROW_LSB   = DCCM_WIDTH_BITS + DCCM_BANK_BITS;
  localparam int ROW_BITS  = DCCM_BITS - ROW_LSB;
  localparam int NUM_BANKS = 1 << DCCM_BANK_BITS;
  localparam int NUM_ROWS  = 1 << ROW_BITS;

  logic [DCCM_FDATA_WIDTH-1:0] mem [NUM_BANKS][NUM_ROWS];

  logic [DCCM_BANK_BITS-1:0] wr_bank, lo_bank, hi_bank;
  logic [ROW_BITS-1:0]       wr_row, lo_row, hi_row;

  assign wr_bank = dccm_wr_addr[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
  assign lo_bank = dccm_rd_addr_lo[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
  assign hi_bank = dccm_rd_addr_hi[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
  assign wr_row  = dccm_wr_addr[DCCM_BITS-1:ROW_LSB];
  assign lo_row  = dccm_rd_addr_lo[DCCM_BITS-1:ROW_LSB];
  assign hi_row  = dccm_rd_addr_hi[DCCM_BITS-1:ROW_LSB];

  logic                        pend_valid;
  logic [DCCM_BANK_BITS-1:0]   pend_bank;
  logic [ROW_BITS-1:0]         pend_row;
  logic [DCCM_FDATA_WIDTH-1:0] pend_data;

  logic [NUM_BANKS-1:0] busy;
  logic retire, direct, pend_hit, to_buf, drop, fwd_lo, fwd_hi, conflict;

  always_comb begin
    busy = '0;
    if (dccm_rden) begin
      busy[lo_bank] = 1'b1;
      busy[hi_bank] = 1'b1;
    end
  end

  // Decision order: pend retires first; a new write may not share the retiring bank.
  assign retire   = pend_valid & ~busy[pend_bank];
  assign direct   = dccm_wren & ~busy[wr_bank] & ~(retire & (wr_bank == pend_bank));
  assign pend_hit = pend_valid & (wr_bank == pend_bank) & (wr_row == pend_row);
  assign to_buf   = dccm_wren & ~direct & (~pend_valid | retire | pend_hit);
  assign drop     = dccm_wren & ~direct & pend_valid & ~retire & ~pend_hit;

  assign fwd_lo   = pend_valid & (lo_bank == pend_bank) & (lo_row == pend_row);
  assign fwd_hi   = pend_valid & (hi_bank == pend_bank) & (hi_row == pend_row);
  assign conflict = dccm_rden & (lo_bank == hi_bank) & (lo_row != hi_row);

  always_ff @(posedge clk) begin
    if (retire) mem[pend_bank][pend_row] <= pend_data;
    if (direct) mem[wr_bank][wr_row]     <= dccm_wr_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dccm_rd_data_lo  <= '0;
      dccm_rd_data_hi  <= '0;
      dccm_wr_overflow <= 1'b0;
      dccm_rd_conflict <= 1'b0;
      pend_valid       <= 1'b0;
      pend_bank        <= '0;
      pend_row         <= '0;
      pend_data        <= '0;
    end else begin
      if (dccm_rden) begin
        dccm_rd_data_lo <= fwd_lo ? pend_data : mem[lo_bank][lo_row];
        dccm_rd_data_hi <= fwd_hi ? pend_data : mem[hi_bank][hi_row];
      end
      dccm_rd_conflict <= conflict;
      if (drop) dccm_wr_overflow <= 1'b1;
      if (to_buf) begin
        pend_valid <= 1'b1;
        pend_bank  <= wr_bank;
        pend_row   <= wr_row;
        pend_data  <= dccm_wr_data;
      end else if (retire) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign dccm_wr_pend = pend_valid;

endmodule

// File: tb/tb_lsu_dccm_mem.sv
// Directed vector bench for lsu_dccm_mem: table of per-cycle stimulus with expected outputs,
// plus a hand sequence for reset asserted while a write is pending.
module tb_lsu_dccm_mem;
  localparam int AW = 12;
  localparam int DW = 39;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          dccm_wren;
  logic [AW-1:0] dccm_wr_addr;
  logic [DW-1:0] dccm_wr_data;
  logic          dccm_rden;
  logic [AW-1:0] dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [DW-1:0] dccm_rd_data_lo, dccm_rd_data_hi;
  logic          dccm_wr_pend, dccm_wr_overflow, dccm_rd_conflict;

  lsu_dccm_mem #(
    .DCCM_BITS(12), .DCCM_BANK_BITS(2), .DCCM_WIDTH_BITS(2), .DCCM_FDATA_WIDTH(39)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .dccm_rden(dccm_rden), .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi),
    .dccm_wr_pend(dccm_wr_pend), .dccm_wr_overflow(dccm_wr_overflow),
    .dccm_rd_conflict(dccm_rd_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wren;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rden;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [DW-1:0] e_lo;
    logic [DW-1:0] e_hi;
    logic          e_pend;
    logic          e_ovf;
    logic          e_conf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [DW-1:0] D100 = 39'h7F12345678;
  localparam logic [DW-1:0] D204 = 39'h0000000011;
  localparam logic [DW-1:0] D214 = 39'h4000000077;
  localparam logic [DW-1:0] D008 = 39'h000000005A;
  localparam logic [DW-1:0] DA5  = 39'h2A000000A5;
  localparam logic [DW-1:0] DB6  = 39'h00000000B6;
  localparam logic [DW-1:0] DC3  = 39'h01000000C3;
  localparam logic [DW-1:0] DE7  = 39'h15000000E7;
  localparam logic [DW-1:0] D000 = 39'h0000000001;
  localparam logic [DW-1:0] D010 = 39'h3F00000002;
  localparam logic [DW-1:0] D99  = 39'h0000000099;

  task automatic add(input logic wren, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic rden, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                     input logic [DW-1:0] e_lo, input logic [DW-1:0] e_hi,
                     input logic e_pend, input logic e_ovf, input logic e_conf);
    vec_t v;
    v.wren = wren; v.wa = wa; v.wd = wd; v.rden = rden; v.lo = lo; v.hi = hi;
    v.e_lo = e_lo; v.e_hi = e_hi; v.e_pend = e_pend; v.e_ovf = e_ovf; v.e_conf = e_conf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wren, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rden, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    dccm_wren = wren; dccm_wr_addr = wa; dccm_wr_data = wd;
    dccm_rden = rden; dccm_rd_addr_lo = lo; dccm_rd_addr_hi = hi;
  endtask

  task automatic check(input string name, input logic [DW-1:0] e_lo, input logic [DW-1:0] e_hi,
                       input logic e_pend, input logic e_ovf, input logic e_conf);
    n_vec++;
    if (dccm_rd_data_lo !== e_lo || dccm_rd_data_hi !== e_hi || dccm_wr_pend !== e_pend ||
        dccm_wr_overflow !== e_ovf || dccm_rd_conflict !== e_conf) begin
      n_err++;
      $display("FAIL %s: got lo=%h hi=%h pend=%b ovf=%b conf=%b, want lo=%h hi=%h pend=%b ovf=%b conf=%b",
               name, dccm_rd_data_lo, dccm_rd_data_hi, dccm_wr_pend, dccm_wr_overflow,
               dccm_rd_conflict, e_lo, e_hi, e_pend, e_ovf, e_conf);
    end
  endtask

  initial begin
    //   wren wa      wd    rden lo      hi       e_lo  e_hi  pend ovf conf
    add(1, 12'h100, D100, 0, 12'h000, 12'h000,  '0,   '0,   0, 0, 0); // 0
    add(0, 12'h000, '0,   1, 12'h100, 12'h100,  D100, D100, 0, 0, 0); // 1 same bank+row
    add(1, 12'h204, D204, 0, 12'h000, 12'h000,  D100, D100, 0, 0, 0); // 2
    add(1, 12'h214, D214, 0, 12'h000, 12'h000,  D100, D100, 0, 0, 0); // 3
    add(1, 12'h008, D008, 0, 12'h000, 12'h000,  D100, D100, 0, 0, 0); // 4
    add(1, 12'h204, DA5,  1, 12'h204, 12'h100,  D204, D100, 1, 0, 0); // 5 read-before-write, park
    add(0, 12'h000, '0,   0, 12'h000, 12'h000,  D204, D100, 0, 0, 0); // 6 retire, hold
    add(0, 12'h000, '0,   1, 12'h204, 12'h204,  DA5,  DA5,  0, 0, 0); // 7
    add(1, 12'h204, DB6,  1, 12'h214, 12'h100,  D214, D100, 1, 0, 0); // 8 park
    add(0, 12'h000, '0,   1, 12'h214, 12'h100,  D214, D100, 1, 0, 0); // 9 held
    add(0, 12'h000, '0,   1, 12'h204, 12'h100,  DB6,  D100, 1, 0, 0); // 10 forward
    add(1, 12'h008, DC3,  1, 12'h204, 12'h008,  DB6,  D008, 1, 1, 0); // 11 drop
    add(1, 12'h204, DE7,  1, 12'h204, 12'h214,  DB6,  D214, 1, 1, 1); // 12 overwrite, conflict
    add(0, 12'h000, '0,   1, 12'h204, 12'h204,  DE7,  DE7,  1, 1, 0); // 13
    add(0, 12'h000, '0,   0, 12'h000, 12'h000,  DE7,  DE7,  0, 1, 0); // 14 retire
    add(0, 12'h000, '0,   1, 12'h204, 12'h100,  DE7,  D100, 0, 1, 0); // 15
    add(0, 12'h000, '0,   1, 12'h008, 12'h008,  D008, D008, 0, 1, 0); // 16 dropped wr absent
    add(1, 12'h000, D000, 0, 12'h000, 12'h000,  D008, D008, 0, 1, 0); // 17
    add(1, 12'h010, D010, 0, 12'h000, 12'h000,  D008, D008, 0, 1, 0); // 18
    add(0, 12'h000, '0,   1, 12'h000, 12'h010,  D000, D010, 0, 1, 1); // 19 conflict
    add(0, 12'h000, '0,   0, 12'h000, 12'h000,  D000, D010, 0, 1, 0); // 20
    add(0, 12'h000, '0,   1, 12'h000, 12'h000,  D000, D000, 0, 1, 0); // 21 no conflict

    rst_l = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 check("reset", '0, '0, 0, 0, 0);
    @(negedge clk) rst_l = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wren, vecs[i].wa, vecs[i].wd, vecs[i].rden, vecs[i].lo, vecs[i].hi);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].e_lo, vecs[i].e_hi, vecs[i].e_pend,
               vecs[i].e_ovf, vecs[i].e_conf);
      @(negedge clk);
    end

    // Reset asserted while a write is parked: outputs clear at once, parked write is lost.
    drive(1, 12'h204, D99, 1, 12'h204, 12'h204);
    @(posedge clk);
    #1 check("park_before_reset", DE7, DE7, 1, 1, 0);
    @(negedge clk);
    drive(0, '0, '0, 0, '0, '0);
    rst_l = 1'b0;
    #1 check("async_reset", '0, '0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    @(posedge clk);
    #1 check("idle_after_reset", '0, '0, 0, 0, 0);
    @(negedge clk);
    drive(0, '0, '0, 1, 12'h204, 12'h204);
    @(posedge clk);
    #1 check("pend_dropped", DE7, DE7, 0, 0, 0);
    @(negedge clk);
    drive(0, '0, '0, 0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
